// File: rtl/lcd_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : lcd_write_sequencer
// Brief   : HD44780 power-up/init sequencer and single-byte write timing engine
// Revision: 1.0 - initial release
// ============================================================================
module lcd_write_sequencer #(
  parameter int CNT_W    = 20,
  parameter int T_PWRUP  = 750000,
  parameter int T_SETUP  = 2,
  parameter int T_E_HIGH = 12,
  parameter int T_HOLD   = 2,
  parameter int T_EXEC   = 2000,
  parameter int T_CLEAR  = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_on,
  output logic [7:0] lcd_data
);

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_SETUP = 3'd1,
    S_EHIGH = 3'd2,
    S_HOLD  = 3'd3,
    S_EXEC  = 3'd4,
    S_IDLE  = 3'd5
  } state_t;

  // Terminal counts; a zero delay collapses to a single cycle.
  localparam logic [CNT_W-1:0] c_PWRUP_LAST = CNT_W'((T_PWRUP  > 1) ? T_PWRUP  - 1 : 0);
  localparam logic [CNT_W-1:0] c_SETUP_LAST = CNT_W'((T_SETUP  > 1) ? T_SETUP  - 1 : 0);
  localparam logic [CNT_W-1:0] c_EHIGH_LAST = CNT_W'((T_E_HIGH > 1) ? T_E_HIGH - 1 : 0);
  localparam logic [CNT_W-1:0] c_HOLD_LAST  = CNT_W'((T_HOLD   > 1) ? T_HOLD   - 1 : 0);
  localparam logic [CNT_W-1:0] c_EXEC_LAST  = CNT_W'((T_EXEC   > 1) ? T_EXEC   - 1 : 0);
  localparam logic [CNT_W-1:0] c_CLEAR_LAST = CNT_W'((T_CLEAR  > 1) ? T_CLEAR  - 1 : 0);
  localparam logic [1:0]       c_INIT_LAST  = 2'd3;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_init_idx;
  logic [1:0]       w_init_idx_nxt;
  logic             r_init_done;
  logic             r_lcd_e;
  logic             r_lcd_rs;
  logic             r_lcd_on;
  logic [7:0]       r_lcd_data;
  logic             w_load_init;
  logic             w_hs;
  logic             w_done_set;
  logic             w_is_clear;
  logic [CNT_W-1:0] w_exec_last;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction

  // Clear/home commands need the long execution wait.
  assign w_is_clear  = !r_lcd_rs && (r_lcd_data == 8'h01 || r_lcd_data == 8'h02 ||
                                     r_lcd_data == 8'h03);
  assign w_exec_last = w_is_clear ? c_CLEAR_LAST : c_EXEC_LAST;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_PWRUP;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_idx_nxt = r_init_idx;
    w_load_init    = 1'b0;
    w_hs           = 1'b0;
    w_done_set     = 1'b0;
    case (r_state)
      S_PWRUP: if (r_cnt == c_PWRUP_LAST) begin
        w_state_nxt = S_SETUP;
        w_load_init = 1'b1;
      end
      S_SETUP: if (r_cnt == c_SETUP_LAST) w_state_nxt = S_EHIGH;
      S_EHIGH: if (r_cnt == c_EHIGH_LAST) w_state_nxt = S_HOLD;
      S_HOLD:  if (r_cnt == c_HOLD_LAST)  w_state_nxt = S_EXEC;
      S_EXEC: if (r_cnt == w_exec_last) begin
        if (!r_init_done && r_init_idx != c_INIT_LAST) begin
          w_state_nxt    = S_SETUP;
          w_init_idx_nxt = r_init_idx + 2'd1;
          w_load_init    = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_done_set  = !r_init_done;
        end
      end
      S_IDLE: if (wr_valid && r_init_done) begin
        w_state_nxt = S_SETUP;
        w_hs        = 1'b1;
      end
      default: w_state_nxt = S_PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_init_idx  <= 2'd0;
      r_init_done <= 1'b0;
      r_lcd_e     <= 1'b0;
      r_lcd_rs    <= 1'b0;
      r_lcd_on    <= 1'b0;
      r_lcd_data  <= 8'h00;
    end else begin
      r_cnt      <= (w_state_nxt != r_state || r_state == S_IDLE) ? '0 : r_cnt + 1'b1;
      r_init_idx <= w_init_idx_nxt;
      r_lcd_on   <= 1'b1;
      // E is registered from the next state so it tracks EHIGH exactly.
      r_lcd_e    <= (w_state_nxt == S_EHIGH);
      if (w_done_set) r_init_done <= 1'b1;
      if (w_load_init) begin
        r_lcd_rs   <= 1'b0;
        r_lcd_data <= init_byte(w_init_idx_nxt);
      end else if (w_hs) begin
        r_lcd_rs   <= wr_rs;
        r_lcd_data <= wr_data;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign wr_ready  = (r_state == S_IDLE) && r_init_done;
  assign init_done = r_init_done;
  assign lcd_e     = r_lcd_e;
  assign lcd_rs    = r_lcd_rs;
  assign lcd_rw    = 1'b0;
  assign lcd_on    = r_lcd_on;
  assign lcd_data  = r_lcd_data;

endmodule
`default_nettype wire

// File: tb/tb_lcd_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_lcd_write_sequencer
// Brief   : Directed bench for init sequence, write timing and reset replay
// Revision: 1.0 - initial release
// ============================================================================
module tb_lcd_write_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, init_done, busy, lcd_e, lcd_rs, lcd_rw, lcd_on;
  logic [7:0] lcd_data;

  int n_checks = 0;
  int n_errors = 0;

  lcd_write_sequencer #(
    .CNT_W(20), .T_PWRUP(100), .T_SETUP(2), .T_E_HIGH(4),
    .T_HOLD(2), .T_EXEC(10), .T_CLEAR(50)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_rs(wr_rs), .wr_data(wr_data), .init_done(init_done), .busy(busy),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_on(lcd_on),
    .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic       hold;
    logic [7:0] lat;
  } vec_t;

  vec_t       vecs [9];
  logic [7:0] exp_init [4];
  int         exp_start [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    wr_valid = 1'b0;
    step();
    chk("rst_lcd_e", lcd_e, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_lcd_on", lcd_on, 0);
    chk("rst_busy", busy, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_lcd_rs", lcd_rs, 0);
    chk("rst_lcd_data", lcd_data, 8'h00);
    chk("rst_lcd_rw", lcd_rw, 0);
    rst = 1'b0;
  endtask

  // Cycle 0 is the cycle right after the reset edge; wr_valid is pushed during init.
  task automatic check_init();
    int   np = 0;
    logic prev_e = 1'b0;
    int   st [4];
    logic rsv [4];
    logic [7:0] dat [4];
    int   wid [4];
    for (int i = 0; i < 4; i++) begin st[i] = -1; rsv[i] = 1'b1; dat[i] = 8'hxx; wid[i] = 0; end
    wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'hFF;
    for (int c = 1; c <= 212; c++) begin
      step();
      if (lcd_e && !prev_e) begin
        if (np < 4) begin st[np] = c; rsv[np] = lcd_rs; dat[np] = lcd_data; end
        np++;
      end
      if (lcd_e && np >= 1 && np <= 4) wid[np-1]++;
      prev_e = lcd_e;
      if (c == 1) chk("lcd_on_after_rst", lcd_on, 1);
      if (c == 211 || c == 212) begin
        chk("init_done_edge", init_done, (c >= 212) ? 1 : 0);
        chk("init_wr_ready_edge", wr_ready, (c >= 212) ? 1 : 0);
      end else if (wr_ready !== 1'b0) begin
        chk("init_wr_ready_low", wr_ready, 0);
      end
      if (c >= 210) wr_valid = 1'b0;
    end
    chk("init_pulse_count", np, 4);
    for (int i = 0; i < 4; i++) begin
      chk("init_byte", dat[i], exp_init[i]);
      chk("init_rs", rsv[i], 0);
      chk("init_e_start", st[i], exp_start[i]);
      chk("init_e_width", wid[i], 4);
    end
  endtask

  // Applies one record; with hold set, wr_valid stays high and wr_data churns while busy.
  task automatic do_write(input vec_t v);
    int guard = 0;
    while (!wr_ready && guard < 200) begin step(); guard++; end
    if (!wr_ready) begin
      chk("wr_ready_timeout", wr_ready, 1);
      return;
    end
    wr_valid = 1'b1; wr_rs = v.rs; wr_data = v.data;
    for (int n = 1; n <= int'(v.lat); n++) begin
      step();
      if (!v.hold) wr_valid = 1'b0;
      else if (n < int'(v.lat)) begin
        wr_rs   = ~wr_rs;
        wr_data = 8'($urandom);
      end
      if (n == 1) chk("wr_busy_start", busy, 1);
      if (lcd_rs !== v.rs || lcd_data !== v.data) begin
        chk("wr_lcd_rs", lcd_rs, v.rs);
        chk("wr_lcd_data", lcd_data, v.data);
      end
      if (lcd_e !== ((n >= 3 && n <= 6) ? 1'b1 : 1'b0))
        chk("wr_lcd_e", lcd_e, (n >= 3 && n <= 6) ? 1 : 0);
      if (n == int'(v.lat) - 1) chk("wr_ready_before_end", wr_ready, 0);
      if (n == int'(v.lat)) begin
        chk("wr_ready_at_end", wr_ready, 1);
        chk("wr_busy_at_end", busy, 0);
      end
    end
  endtask

  initial begin
    exp_init[0] = 8'h38; exp_init[1] = 8'h0C; exp_init[2] = 8'h01; exp_init[3] = 8'h06;
    exp_start[0] = 102; exp_start[1] = 120; exp_start[2] = 138; exp_start[3] = 196;
    vecs[0] = '{1'b1, 8'h41, 1'b0, 8'd19};
    vecs[1] = '{1'b0, 8'h01, 1'b0, 8'd59};
    vecs[2] = '{1'b0, 8'h80, 1'b0, 8'd19};
    vecs[3] = '{1'b0, 8'h02, 1'b1, 8'd59};
    vecs[4] = '{1'b1, 8'h5A, 1'b1, 8'd19};
    vecs[5] = '{1'b0, 8'h03, 1'b0, 8'd59};
    vecs[6] = '{1'b1, 8'h01, 1'b0, 8'd19};
    vecs[7] = '{1'b0, 8'h04, 1'b0, 8'd19};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 8'd19};

    step();
    do_reset();
    check_init();
    for (int i = 0; i < 9; i++) do_write(vecs[i]);

    // Reset while E is high, then confirm init replays and writes still work.
    begin
      int guard = 0;
      wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h55;
      step();
      wr_valid = 1'b0;
      while (!lcd_e && guard < 20) begin step(); guard++; end
      chk("mid_write_e_high", lcd_e, 1);
    end
    do_reset();
    check_init();
    do_write(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
